// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and the memory-access FSM state type.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size lives in fun3[1:0]; fun3[2] selects zero-extension.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_REQ   = 2'd1;
    localparam state_t ST_DONE  = 2'd2;
    localparam state_t ST_FAULT = 2'd3;

    // Stores only have b/h/w; loads reject the x11 size codes.
    function automatic logic fun3_ok(input logic [2:0] f3, input logic is_store);
        if (is_store) return f3 <= F3_W;
        return f3[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data selection/extension for a 32-bit memory word.
module lsu_lane_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  fun3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword lane ignores addr_lo[0]: unaligned halves are force-aligned.
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (fun3[1:0])
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = fun3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = fun3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
        if (is_store) rdata_ext = '0;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store memory access FSM with request timeout. Define MISALIGN_TRAP_EN
// to fault misaligned h/w accesses instead of force-aligning them.
module mem_access_ctrl
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Load,
    input  logic        Store,
    input  logic [2:0]  fun3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata_out,
    output logic        done,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          we_q, we_d;
    logic [2:0]    fun3_q, fun3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [3:0]    be;
    logic [31:0]   wdata_rep, rdata_ext;
    logic          misalign, bad_req;

`ifdef MISALIGN_TRAP_EN
    assign misalign = (fun3[1:0] == SZ_H && addr[0]) ||
                      (fun3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign bad_req = (Load && Store) || !fun3_ok(fun3, Store) || misalign;

    lsu_lane_align u_align (
        .fun3      (fun3_q),
        .addr_lo   (addr_q[1:0]),
        .is_store  (we_q),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_req_d = mem_req_q;
        we_d      = we_q;
        fun3_d    = fun3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (Load || Store) begin
                    if (bad_req) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d   = ST_REQ;
                        mem_req_d = 1'b1;
                        we_d      = Store;
                        fun3_d    = fun3;
                        addr_d    = addr;
                        wdata_d   = wdata;
                        cnt_d     = '0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    rdata_d   = rdata_ext;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = ST_FAULT;
                    mem_req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            we_q      <= 1'b0;
            fun3_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_req_q <= mem_req_d;
            we_q      <= we_d;
            fun3_q    <= fun3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Bus outputs are zero whenever no request is outstanding.
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q && we_q;
    assign mem_addr  = mem_req_q ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be    = mem_req_q ? be : 4'd0;
    assign mem_wdata = mem_req_q ? wdata_rep : 32'd0;

    assign stall     = !rst && ((state_q == ST_IDLE && (Load || Store)) || state_q == ST_REQ);
    assign done      = (state_q == ST_DONE) || (state_q == ST_FAULT);
    assign fault     = (state_q == ST_FAULT);
    assign rdata_out = (state_q == ST_DONE) ? rdata_q : 32'd0;

endmodule
